// File: rtl/dac_i2s_tx.sv
// dac_i2s_tx: sample FIFO feeding an I2S master serializer; both slots carry the same sample.
// Latency: a sample is popped at the next frame boundary with its MSB on sd that cycle; backpressure: in_ready drops when full, extra samples are dropped and flagged.

module dac_i2s_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    output logic                   push_rdy,
    input  logic                   pop_vld,
    output logic [W-1:0]           pop_dat,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Readiness comes from registered occupancy only, so a same-cycle pop never frees a slot.
    assign push_rdy = (level != FULL_LVL);
    assign empty    = (level == '0);
    assign push     = push_vld && push_rdy;
    assign pop      = pop_vld && !empty;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

module dac_i2s_tx #(
    parameter int DATA_W     = 16,
    parameter int SCK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_en,
    input  logic [DATA_W-1:0]           in_sample,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        sck,
    output logic                        ws,
    output logic                        sd,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        underflow
);
    localparam int FRAME_BITS = 2 * DATA_W;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int IDX_W      = $clog2(DATA_W);
    localparam int DIV_W      = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(SCK_DIV - 1);
    localparam logic [IDX_W-1:0] MSB_IDX  = IDX_W'(DATA_W - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] frame_q;
    logic [DATA_W-1:0] fifo_dat;
    logic              fifo_empty;

    logic              div_tc;
    logic              fall_evt;
    logic              frame_bnd;
    logic              pop_req;
    logic [BIT_W-1:0]  bit_nxt;
    logic [BIT_W-1:0]  slot_bit;
    logic [IDX_W-1:0]  slot_idx;
    logic [DATA_W-1:0] frame_nxt;
    logic              sd_nxt;
    logic              ws_nxt;

    dac_i2s_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (in_valid),
        .push_dat (in_sample),
        .push_rdy (in_ready),
        .pop_vld  (pop_req),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_comb begin
        div_tc    = (div_cnt == DIV_TC);
        fall_evt  = tx_en && div_tc && sck;
        frame_bnd = fall_evt && (bit_cnt == LAST_BIT);
        pop_req   = frame_bnd && !fifo_empty;
        bit_nxt   = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        // Both slots index the same word; fold the right-slot position back onto 0..DATA_W-1.
        slot_bit  = (bit_nxt < BIT_W'(DATA_W)) ? bit_nxt : bit_nxt - BIT_W'(DATA_W);
        slot_idx  = IDX_W'(slot_bit);
        frame_nxt = pop_req ? fifo_dat : frame_q;
        sd_nxt    = frame_nxt[MSB_IDX - slot_idx];
        // ws switches one bit ahead of each slot's MSB.
        ws_nxt    = (bit_nxt >= BIT_W'(DATA_W - 1)) && (bit_nxt <= BIT_W'(FRAME_BITS - 2));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= LAST_BIT;
            frame_q <= '0;
            sck     <= 1'b0;
            ws      <= 1'b0;
            sd      <= 1'b0;
        end else if (!tx_en) begin
            div_cnt <= '0;
            bit_cnt <= LAST_BIT;
            frame_q <= '0;
            sck     <= 1'b0;
            ws      <= 1'b0;
            sd      <= 1'b0;
        end else begin
            div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
            if (div_tc) sck <= ~sck;
            if (fall_evt) begin
                bit_cnt <= bit_nxt;
                frame_q <= frame_nxt;
                sd      <= sd_nxt;
                ws      <= ws_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (in_valid && !in_ready) overflow  <= 1'b1;
            if (frame_bnd && fifo_empty) underflow <= 1'b1;
        end
    end
endmodule
